// File: rtl/ov5640_capture_ctrl.sv
// Frame capture sequencer for an OV5640 DVP stream: settle, request buffer, capture, ping-pong.
// Optional watchdog compiled in with OV5640_CAPTURE_CTRL_TIMEOUT_EN.
module ov5640_capture_ctrl #(
  parameter int IMG_W       = 16,
  parameter int IMG_H       = 12,
  parameter int SKIP_FRAMES = 10,
  parameter int TIMEOUT     = 1000000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic        Stop,
  input  logic        Continuous,
  input  logic        DataVs,
  input  logic        DataHs,
  input  logic        DataValid,
  output logic        BufReq,
  input  logic        BufGnt,
  output logic        CaptureEn,
  output logic        BufSel,
  output logic        Busy,
  output logic        FrameStart,
  output logic        FrameDone,
  output logic        FrameErr,
  output logic [15:0] FrameCnt,
  output logic [15:0] DropCnt,
  output logic        Timeout
);

  // state   | meaning
  // IDLE    | stopped, waiting for Start
  // SKIP    | discarding settling frames after Start
  // ARM     | requesting a frame buffer
  // WAIT_VS | buffer granted, waiting for the next frame boundary
  // CAPTURE | frame in progress, pixel writes enabled
  // DONE    | one-cycle frame close-out
  typedef enum logic [2:0] {IDLE, SKIP, ARM, WAIT_VS, CAPTURE, DONE} state_t;

  localparam int PIX_TOTAL = IMG_W * IMG_H;
  localparam int PW  = $clog2(PIX_TOTAL + 1);
  localparam int LW  = $clog2(IMG_H + 2);
  localparam int SKW = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;
  localparam logic [PW-1:0]  PIX_LAST  = PW'(PIX_TOTAL - 1);
  localparam logic [LW-1:0]  LINES     = LW'(IMG_H);
  localparam logic [SKW-1:0] SKIP_LAST = SKW'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);

  state_t         state;
  logic [PW-1:0]  pix_cnt;
  logic [LW-1:0]  line_cnt;
  logic [SKW-1:0] skip_cnt;
  logic           cont_q;
  logic           stop_pend;
  logic           vs_q, hs_q, edge_ok;
  logic           vs_rise, hs_fall;
  logic           wd_hit;

  // edge_ok masks the first cycle after reset so a level already high is not an edge
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      vs_q    <= 1'b0;
      hs_q    <= 1'b0;
      edge_ok <= 1'b0;
    end else begin
      vs_q    <= DataVs;
      hs_q    <= DataHs;
      edge_ok <= 1'b1;
    end
  end

  assign vs_rise = edge_ok & DataVs & ~vs_q;
  assign hs_fall = edge_ok & hs_q & ~DataHs;

`ifdef OV5640_CAPTURE_CTRL_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_cnt;
  state_t         state_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wd_cnt  <= '0;
      state_q <= IDLE;
    end else begin
      state_q <= state;
      if (vs_rise || (state != state_q) || (state == IDLE))
        wd_cnt <= '0;
      else if (!wd_hit)
        wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign wd_hit = (wd_cnt == WDW'(TIMEOUT - 1)) && (state == state_q) &&
                  (state inside {SKIP, ARM, WAIT_VS, CAPTURE});
`else
  assign wd_hit = 1'b0 && (TIMEOUT < 0);
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      BufReq     <= 1'b0;
      CaptureEn  <= 1'b0;
      BufSel     <= 1'b0;
      Busy       <= 1'b0;
      FrameStart <= 1'b0;
      FrameDone  <= 1'b0;
      FrameErr   <= 1'b0;
      Timeout    <= 1'b0;
      FrameCnt   <= 16'h0000;
      DropCnt    <= 16'h0000;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      skip_cnt   <= '0;
      cont_q     <= 1'b0;
      stop_pend  <= 1'b0;
    end else begin
      FrameStart <= 1'b0;
      FrameDone  <= 1'b0;
      FrameErr   <= 1'b0;
      Timeout    <= 1'b0;
      if (wd_hit) begin
        state     <= IDLE;
        Busy      <= 1'b0;
        BufReq    <= 1'b0;
        CaptureEn <= 1'b0;
        Timeout   <= 1'b1;
        stop_pend <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (Start && !Stop) begin
              state     <= SKIP;
              Busy      <= 1'b1;
              skip_cnt  <= '0;
              stop_pend <= 1'b0;
            end
          end
          SKIP: begin
            if (Stop) begin
              state <= IDLE;
              Busy  <= 1'b0;
            end else if ((SKIP_FRAMES == 0) || (vs_rise && (skip_cnt == SKIP_LAST))) begin
              state  <= ARM;
              BufReq <= 1'b1;
              cont_q <= Continuous;
            end else if (vs_rise) begin
              skip_cnt <= skip_cnt + 1'b1;
            end
          end
          ARM: begin
            if (Stop) begin
              state  <= IDLE;
              Busy   <= 1'b0;
              BufReq <= 1'b0;
            end else if (BufGnt) begin
              state <= WAIT_VS;
            end else if (vs_rise && (DropCnt != 16'hFFFF)) begin
              DropCnt <= DropCnt + 16'd1;
            end
          end
          WAIT_VS: begin
            if (Stop) begin
              state  <= IDLE;
              Busy   <= 1'b0;
              BufReq <= 1'b0;
            end else if (vs_rise) begin
              state      <= CAPTURE;
              FrameStart <= 1'b1;
              CaptureEn  <= 1'b1;
              pix_cnt    <= '0;
              line_cnt   <= '0;
            end
          end
          CAPTURE: begin
            if (Stop)
              stop_pend <= 1'b1;
            if (hs_fall)
              line_cnt <= line_cnt + 1'b1;
            if (vs_rise) begin
              FrameErr  <= 1'b1;
              CaptureEn <= 1'b0;
              stop_pend <= 1'b0;
              if (cont_q && !Stop && !stop_pend) begin
                state  <= ARM;
                BufReq <= 1'b1;
                cont_q <= Continuous;
              end else begin
                state  <= IDLE;
                Busy   <= 1'b0;
                BufReq <= 1'b0;
              end
            end else if (DataValid) begin
              pix_cnt <= pix_cnt + 1'b1;
              if (pix_cnt == PIX_LAST) begin
                state     <= DONE;
                CaptureEn <= 1'b0;
                BufReq    <= 1'b0;
              end
            end
          end
          DONE: begin
            // the last line's HS usually falls in this cycle, so it is counted here
            FrameDone <= 1'b1;
            if ((line_cnt + LW'(hs_fall)) != LINES)
              FrameErr <= 1'b1;
            BufSel    <= ~BufSel;
            FrameCnt  <= FrameCnt + 16'd1;
            stop_pend <= 1'b0;
            if (cont_q && !stop_pend && !Stop) begin
              state  <= ARM;
              BufReq <= 1'b1;
              cont_q <= Continuous;
            end else begin
              state <= IDLE;
              Busy  <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            Busy   <= 1'b0;
            BufReq <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ov5640_capture_ctrl.sv
// Directed bench for ov5640_capture_ctrl: 16x12 frames, two settling frames.
module tb_ov5640_capture_ctrl;

  localparam int IMG_W = 16;
  localparam int IMG_H = 12;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start = 1'b0, Stop = 1'b0, Continuous = 1'b0;
  logic        DataVs = 1'b0, DataHs = 1'b0, DataValid = 1'b0;
  logic        BufGnt = 1'b1;
  logic        BufReq, CaptureEn, BufSel, Busy, FrameStart, FrameDone, FrameErr, Timeout;
  logic [15:0] FrameCnt, DropCnt;

  int checks = 0;
  int errors = 0;
  int n_start = 0, n_done = 0, n_err = 0, n_to = 0;
  int s0, d0, e0, t0;

  ov5640_capture_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .SKIP_FRAMES(2), .TIMEOUT(500)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Stop(Stop), .Continuous(Continuous),
    .DataVs(DataVs), .DataHs(DataHs), .DataValid(DataValid),
    .BufReq(BufReq), .BufGnt(BufGnt), .CaptureEn(CaptureEn), .BufSel(BufSel),
    .Busy(Busy), .FrameStart(FrameStart), .FrameDone(FrameDone), .FrameErr(FrameErr),
    .FrameCnt(FrameCnt), .DropCnt(DropCnt), .Timeout(Timeout)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (FrameStart) n_start++;
    if (FrameDone)  n_done++;
    if (FrameErr)   n_err++;
    if (Timeout)    n_to++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap;
    s0 = n_start; d0 = n_done; e0 = n_err; t0 = n_to;
  endtask

  task automatic pulse_start;
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
  endtask

  task automatic pulse_stop;
    @(negedge Clk); Stop = 1'b1;
    @(negedge Clk); Stop = 1'b0;
  endtask

  task automatic vs_pulse;
    @(negedge Clk); DataVs = 1'b1;
    repeat (2) @(negedge Clk);
    DataVs = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  // npix pixels in lines of IMG_W; Stop rides along with pixel index stop_at
  task automatic frame(input int npix, input int stop_at);
    int p;
    p = 0;
    vs_pulse();
    for (int l = 0; l < IMG_H && p < npix; l++) begin
      for (int x = 0; x < IMG_W && p < npix; x++) begin
        @(negedge Clk);
        DataHs = 1'b1; DataValid = 1'b1; Stop = (p == stop_at);
        p++;
      end
      @(negedge Clk);
      DataHs = 1'b0; DataValid = 1'b0; Stop = 1'b0;
      @(negedge Clk);
    end
    repeat (4) @(negedge Clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    repeat (3) @(negedge Clk);
    check("reset_ctrl", {BufReq, CaptureEn, BufSel, Busy, FrameStart, FrameDone, FrameErr, Timeout}, 0);
    check("reset_cnts", {FrameCnt, DropCnt}, 0);
    Rst_n = 1'b1;
    repeat (3) @(negedge Clk);
    check("idle_after_release", Busy, 0);

    // Start and Stop together in IDLE: Stop wins
    @(negedge Clk); Start = 1'b1; Stop = 1'b1;
    @(negedge Clk); Start = 1'b0; Stop = 1'b0;
    check("start_stop_same_cycle_busy", Busy, 0);

    // single shot: frames 1,2 skipped, 3 captured, 4 ignored
    Continuous = 1'b0;
    snap();
    pulse_start();
    check("single_busy_after_start", Busy, 1);
    frame(192, -1);
    frame(192, -1);
    check("single_no_start_during_skip", n_start - s0, 0);
    check("single_armed_bufreq", BufReq, 1);
    frame(192, -1);
    check("single_start_on_3rd_vs", n_start - s0, 1);
    check("single_done_once", n_done - d0, 1);
    check("single_no_err", n_err - e0, 0);
    check("single_framecnt", FrameCnt, 1);
    check("single_bufsel", BufSel, 1);
    check("single_idle", {Busy, BufReq, CaptureEn}, 0);
    frame(192, -1);
    check("single_frame4_ignored", n_start - s0, 1);

    // continuous with one lost frame for lack of grant
    Continuous = 1'b1;
    BufGnt = 1'b0;
    snap();
    pulse_start();
    frame(192, -1);
    frame(192, -1);
    check("cont_dropcnt_before", DropCnt, 0);
    frame(192, -1);
    check("cont_dropcnt_after", DropCnt, 1);
    check("cont_no_capture_without_gnt", n_start - s0, 0);
    @(negedge Clk); BufGnt = 1'b1;
    frame(192, -1);
    check("cont_framecnt_a", FrameCnt, 2);
    check("cont_bufsel_a", BufSel, 0);
    frame(192, -1);
    check("cont_framecnt_b", FrameCnt, 3);
    check("cont_bufsel_b", BufSel, 1);
    check("cont_err_free", n_err - e0, 0);
    check("cont_still_busy", {Busy, BufReq}, 2'b11);

    // truncated frame: 100 pixels then an early frame boundary
    snap();
    frame(100, -1);
    check("trunc_capturing", CaptureEn, 1);
    frame(192, -1);
    check("trunc_err_pulse", n_err - e0, 1);
    check("trunc_no_done", n_done - d0, 0);
    check("trunc_framecnt", FrameCnt, 3);
    check("trunc_bufsel", BufSel, 1);
    check("trunc_only_one_start", n_start - s0, 1);
    check("trunc_capen_low", CaptureEn, 0);
    pulse_stop();
    check("stop_in_wait_vs", {Busy, BufReq}, 0);

    // Stop mid-capture in continuous mode: frame finishes, then IDLE
    snap();
    pulse_start();
    frame(192, -1);
    frame(192, -1);
    frame(192, 50);
    check("stopcap_done", n_done - d0, 1);
    check("stopcap_no_err", n_err - e0, 0);
    check("stopcap_framecnt", FrameCnt, 4);
    check("stopcap_bufsel", BufSel, 0);
    check("stopcap_idle", {Busy, BufReq, CaptureEn}, 0);

    // asynchronous reset in the middle of a frame
    Continuous = 1'b0;
    snap();
    pulse_start();
    frame(192, -1);
    frame(192, -1);
    frame(80, -1);
    check("rst_capturing", {CaptureEn, BufReq, Busy}, 3'b111);
    #2 Rst_n = 1'b0;
    #1;
    check("rst_async_ctrl", {BufReq, CaptureEn, BufSel, Busy, FrameStart, FrameDone, FrameErr, Timeout}, 0);
    check("rst_async_cnts", {FrameCnt, DropCnt}, 0);
    DataVs = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_no_done_err", (n_done - d0) + (n_err - e0), 0);
    Rst_n = 1'b1;
    repeat (5) @(negedge Clk);
    check("rst_release_idle", Busy, 0);
    DataVs = 1'b0;
    repeat (2) @(negedge Clk);

    // watchdog: sit in WAIT_VS with no frame boundary
    snap();
    pulse_start();
    vs_pulse();
    vs_pulse();
    check("wd_waiting", {Busy, BufReq}, 2'b11);
    repeat (520) @(negedge Clk);
`ifdef OV5640_CAPTURE_CTRL_TIMEOUT_EN
    check("wd_timeout_pulse", n_to - t0, 1);
    check("wd_idle", {Busy, BufReq, CaptureEn}, 0);
`else
    check("wd_absent_no_timeout", n_to - t0, 0);
    check("wd_absent_still_waiting", Busy, 1);
    pulse_stop();
    check("wd_absent_stop_idle", Busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
